// File: rtl/csa_serial_acc_pkg.sv
// Shared types and constants for the serial carry-save accumulator.
// Optional feature macro: CSA_ACC_CLEAR_EN (adds a Clear abort input to csa_serial_acc).
package csa_pkg;

  localparam int DEF_N_OPS = 10;
  localparam int DEF_W_IN  = 8;
  localparam int DEF_W_OUT = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // The operand counter must be able to hold N_OPS itself.
  function automatic int cnt_w(input int n_ops);
    return $clog2(n_ops + 1);
  endfunction

endpackage

// File: rtl/csa_serial_acc_if.sv
// Operand-in / result-out handshake bundle for csa_serial_acc.
// The master side feeds operands and takes results; the slave side is the accumulator.
interface csa_serial_acc_if
  import csa_pkg::*;
#(
  parameter int W_IN  = DEF_W_IN,
  parameter int W_OUT = DEF_W_OUT
);
  logic             In_Valid;
  logic [W_IN-1:0]  In_Data;
  logic             In_Ready;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [W_OUT-1:0] Sum;
  logic             Co;

  modport master (
    output In_Valid, In_Data, Out_Ready,
    input  In_Ready, Out_Valid, Sum, Co
  );

  modport slave (
    input  In_Valid, In_Data, Out_Ready,
    output In_Ready, Out_Valid, Sum, Co
  );
endinterface

// File: rtl/csa_serial_acc_cell.sv
// W-bit 3:2 carry-save compressor: s is the bitwise sum, c the majority
// already moved up one bit position (top majority bit falls off).
module csa_cell #(
  parameter int W = 12
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);
  logic [W-1:0] maj;

  assign s   = x ^ y ^ z;
  assign maj = (x & y) | (x & z) | (y & z);
  assign c   = maj << 1;
endmodule

// File: rtl/csa_serial_acc.sv
// Serial accumulator: sums N_OPS unsigned operands in redundant (S, C) form,
// one carry-save step per accepted operand, then resolves with a single
// carry-propagate add and holds the result until the consumer takes it.
// Optional feature macro: CSA_ACC_CLEAR_EN adds a Clear input that aborts the
// current set without disturbing the last published Sum/Co.
module csa_serial_acc
  import csa_pkg::*;
#(
  parameter int N_OPS = DEF_N_OPS,
  parameter int W_IN  = DEF_W_IN,
  parameter int W_OUT = DEF_W_OUT
) (
  input  logic Clk,
  input  logic Rst,
`ifdef CSA_ACC_CLEAR_EN
  input  logic Clear,
`endif
  csa_serial_acc_if.slave bus
);
  localparam int             CW   = cnt_w(N_OPS);
  localparam logic [CW-1:0]  LAST = CW'(N_OPS - 1);

  state_t           state;
  logic [W_OUT-1:0] s_q, c_q;
  logic [W_OUT-1:0] sum_q;
  logic             co_q;
  logic [CW-1:0]    cnt;
  logic             in_ready_q, out_valid_q;

  logic [W_OUT-1:0] opnd, cell_s, cell_c;
  logic [W_OUT:0]   res;
  logic             accept, clr;

`ifdef CSA_ACC_CLEAR_EN
  assign clr = Clear;
`else
  assign clr = 1'b0;
`endif

  assign opnd   = W_OUT'(bus.In_Data);
  assign accept = bus.In_Valid & in_ready_q;
  assign res    = {1'b0, s_q} + {1'b0, c_q};

  csa_cell #(.W(W_OUT)) u_cell (
    .x (s_q),
    .y (c_q),
    .z (opnd),
    .s (cell_s),
    .c (cell_c)
  );

  assign bus.In_Ready  = in_ready_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Sum       = sum_q;
  assign bus.Co        = co_q;

  // Control FSM plus datapath registers; Rst beats Clear, Clear keeps Sum/Co.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cnt         <= '0;
      sum_q       <= '0;
      co_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (clr) begin
      state       <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            s_q   <= opnd;
            c_q   <= '0;
            cnt   <= CW'(1);
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            s_q <= cell_s;
            c_q <= cell_c;
            cnt <= cnt + 1'b1;
            // Final operand: close the input before the resolve cycle.
            if (cnt == LAST) begin
              state      <= RESOLVE;
              in_ready_q <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          {co_q, sum_q} <= res;
          out_valid_q   <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.Out_Ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_serial_acc.sv
// Bench for csa_serial_acc: directed and random operand sets on an N_OPS=10
// and an N_OPS=16 instance, checked against a plain arithmetic sum model.
// Build with CSA_ACC_CLEAR_EN defined to also exercise the Clear input.
module tb_csa_serial_acc;
  import csa_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  csa_serial_acc_if #(.W_IN(8), .W_OUT(12)) b10 ();
  csa_serial_acc_if #(.W_IN(8), .W_OUT(12)) b16 ();

  logic       iv, ordy, sel, clr;
  logic [7:0] id;

  assign b10.In_Valid  = iv & ~sel;
  assign b16.In_Valid  = iv & sel;
  assign b10.In_Data   = id;
  assign b16.In_Data   = id;
  assign b10.Out_Ready = ordy & ~sel;
  assign b16.Out_Ready = ordy & sel;

  wire        rdy  = sel ? b16.In_Ready  : b10.In_Ready;
  wire        ovld = sel ? b16.Out_Valid : b10.Out_Valid;
  wire [11:0] sum  = sel ? b16.Sum       : b10.Sum;
  wire        co   = sel ? b16.Co        : b10.Co;

  csa_serial_acc #(.N_OPS(10), .W_IN(8), .W_OUT(12)) u10 (
    .Clk   (Clk),
    .Rst   (Rst),
`ifdef CSA_ACC_CLEAR_EN
    .Clear (clr),
`endif
    .bus   (b10)
  );

  csa_serial_acc #(.N_OPS(16), .W_IN(8), .W_OUT(12)) u16 (
    .Clk   (Clk),
    .Rst   (Rst),
`ifdef CSA_ACC_CLEAR_EN
    .Clear (1'b0),
`endif
    .bus   (b16)
  );

  int n_cmp = 0;
  int n_err = 0;
  int last_sum [2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Present one operand and wait (bounded) for the accepting edge.
  task automatic send(input string tag, input logic [7:0] d);
    int t = 0;
    iv = 1'b1;
    id = d;
    while (!rdy && t < 50) begin
      step();
      t++;
    end
    chk({tag, "_send_rdy"}, {31'd0, rdy}, 32'd1);
    step();
    iv = 1'b0;
  endtask

  // Feed a full set with per-operand idle gaps, then check latency and result.
  // hold = cycles the consumer stalls in DONE; hold_iv offers operands meanwhile.
  task automatic run_set(input string tag, input logic [7:0] ops[$], input int gaps[$],
                         input int hold, input logic hold_iv);
    int exp = 0;
    foreach (ops[i]) exp += int'(ops[i]);
    exp = exp % 4096;
    foreach (ops[i]) begin
      send(tag, ops[i]);
      if (i == 0) chk({tag, "_sum_held"}, {20'd0, sum}, last_sum[sel]);
      if (i < ops.size() - 1) begin
        for (int g = 0; g < gaps[i]; g++) begin
          step();
          chk({tag, "_gap_rdy"}, {31'd0, rdy}, 32'd1);
        end
      end
    end
    chk({tag, "_lat1_vld"}, {31'd0, ovld}, 32'd0);
    chk({tag, "_lat1_rdy"}, {31'd0, rdy}, 32'd0);
    step();
    chk({tag, "_lat2_vld"}, {31'd0, ovld}, 32'd1);
    chk({tag, "_sum"}, {20'd0, sum}, exp);
    chk({tag, "_co"}, {31'd0, co}, 32'd0);
    last_sum[sel] = exp;
    if (hold_iv) begin
      iv = 1'b1;
      id = 8'h5A;
    end
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold_vld"}, {31'd0, ovld}, 32'd1);
      chk({tag, "_hold_sum"}, {20'd0, sum}, exp);
      chk({tag, "_hold_rdy"}, {31'd0, rdy}, 32'd0);
    end
    iv   = 1'b0;
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    chk({tag, "_drain_vld"}, {31'd0, ovld}, 32'd0);
    chk({tag, "_drain_rdy"}, {31'd0, rdy}, 32'd1);
  endtask

  logic [7:0] ops[$];
  int         gaps[$];

  task automatic fill_seq(input int first, input int last);
    ops.delete();
    gaps.delete();
    for (int v = first; v <= last; v++) begin
      ops.push_back(8'(v));
      gaps.push_back(0);
    end
  endtask

  task automatic fill_rand(input int n);
    ops.delete();
    gaps.delete();
    for (int k = 0; k < n; k++) begin
      ops.push_back(8'($urandom_range(0, 255)));
      gaps.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
  endtask

  initial begin
    iv = 1'b0; id = '0; ordy = 1'b0; sel = 1'b0; clr = 1'b0;

    // Reset with an operand on the bus: it must be discarded.
    Rst = 1'b1;
    iv  = 1'b1;
    id  = 8'hFF;
    step();
    step();
    chk("rst_vld", {31'd0, ovld}, 32'd0);
    chk("rst_sum", {20'd0, sum}, 32'd0);
    chk("rst_co", {31'd0, co}, 32'd0);
    iv  = 1'b0;
    Rst = 1'b0;
    chk("rst_rdy", {31'd0, rdy}, 32'd1);

    // 1..10 back to back.
    fill_seq(1, 10);
    run_set("seq55", ops, gaps, 0, 1'b0);

    // 0,0,3..10 with 3-cycle stalls after operands 2 and 7.
    fill_seq(1, 10);
    ops[0] = 8'd0;
    ops[1] = 8'd0;
    gaps[1] = 3;
    gaps[6] = 3;
    run_set("gap52", ops, gaps, 0, 1'b0);

    // Ten operands of 255.
    fill_seq(1, 10);
    foreach (ops[i]) ops[i] = 8'd255;
    run_set("max2550", ops, gaps, 0, 1'b0);

    // Consumer stall for 20 cycles with operands offered, then a fresh set.
    fill_rand(10);
    run_set("stall", ops, gaps, 20, 1'b1);
    fill_seq(1, 10);
    run_set("after_stall", ops, gaps, 0, 1'b0);

    // Reset after the 5th operand: no residue in the next set.
    for (int k = 1; k <= 5; k++) send("abort", 8'(k * 17));
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("abort_vld", {31'd0, ovld}, 32'd0);
    chk("abort_sum", {20'd0, sum}, 32'd0);
    chk("abort_rdy", {31'd0, rdy}, 32'd1);
    last_sum[0] = 0;
    last_sum[1] = 0;
    fill_seq(1, 10);
    run_set("post_rst", ops, gaps, 0, 1'b0);

    // Reset while a result waits in DONE.
    for (int k = 0; k < 10; k++) send("rst_done", 8'd9);
    step();
    chk("rst_done_vld1", {31'd0, ovld}, 32'd1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("rst_done_vld0", {31'd0, ovld}, 32'd0);
    chk("rst_done_sum", {20'd0, sum}, 32'd0);
    chk("rst_done_rdy", {31'd0, rdy}, 32'd1);
    last_sum[0] = 0;
    last_sum[1] = 0;

    // Random sets on the 10-operand instance.
    for (int r = 0; r < 6; r++) begin
      fill_rand(10);
      run_set("rand10", ops, gaps, int'($urandom_range(0, 4)), 1'(r % 2));
    end

    // 16-operand instance: sixteen 255s, then random sets.
    sel = 1'b1;
    fill_seq(1, 16);
    foreach (ops[i]) ops[i] = 8'd255;
    run_set("max4080", ops, gaps, 0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      fill_rand(16);
      run_set("rand16", ops, gaps, int'($urandom_range(0, 3)), 1'b1);
    end
    sel = 1'b0;

`ifdef CSA_ACC_CLEAR_EN
    // Clear after the 4th operand, with an operand presented alongside Clear.
    for (int k = 1; k <= 4; k++) send("clr_mid", 8'(k * 31));
    clr = 1'b1;
    iv  = 1'b1;
    id  = 8'h77;
    step();
    clr = 1'b0;
    iv  = 1'b0;
    chk("clr_mid_vld", {31'd0, ovld}, 32'd0);
    chk("clr_mid_rdy", {31'd0, rdy}, 32'd1);
    chk("clr_mid_sum", {20'd0, sum}, last_sum[0]);
    fill_seq(1, 10);
    run_set("post_clr", ops, gaps, 0, 1'b0);

    // Clear in DONE: Out_Valid drops, the published Sum stays.
    for (int k = 0; k < 10; k++) send("clr_done", 8'd100);
    step();
    chk("clr_done_vld1", {31'd0, ovld}, 32'd1);
    chk("clr_done_sum1", {20'd0, sum}, 32'd1000);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_done_vld0", {31'd0, ovld}, 32'd0);
    chk("clr_done_sum0", {20'd0, sum}, 32'd1000);
    chk("clr_done_rdy", {31'd0, rdy}, 32'd1);
    last_sum[0] = 1000;
    fill_rand(10);
    run_set("post_clr_done", ops, gaps, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csa_serial_acc.md
CSA_SERIAL_ACC -- requirements
Module: csa_serial_acc

Interface
REQ-001 SHALL have parameter N_OPS, default 10, number of operands per sum (2..16).
REQ-002 SHALL have parameter W_IN, default 8, operand width.
REQ-003 SHALL have parameter W_OUT, default 12, result width.
REQ-004 Clk  input  1  single clock; all state changes on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 In_Valid  input  1  operand present on In_Data.
REQ-007 In_Data  input  W_IN  unsigned operand.
REQ-008 In_Ready  output  1  block accepts an operand this cycle.
REQ-009 Out_Valid  output  1  Sum/Co hold a valid result.
REQ-010 Out_Ready  input  1  consumer takes the result this cycle.
REQ-011 Sum  output  W_OUT  resolved sum of N_OPS operands.
REQ-012 Co  output  1  carry out of the W_OUT-bit final resolution add.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, RESOLVE, DONE.
REQ-014 Operand accepted only when In_Valid && In_Ready on a rising edge.
REQ-015 In_Ready SHALL be 1 in IDLE and ACCUM, 0 in RESOLVE and DONE.
REQ-016 IDLE: on accept, load redundant pair (S = zero-extended operand, C = 0), count=1, go ACCUM.
REQ-017 ACCUM: each accept compresses (S, C, operand) through one 3:2 carry-save stage; S <= xor, C <= majority shifted left 1, truncated to W_OUT; count++.
REQ-018 On the accept that makes count == N_OPS, SHALL go RESOLVE; no further operands accepted.
REQ-019 RESOLVE: one cycle; {Co, Sum} <= S + C as a (W_OUT+1)-bit add; go DONE.
REQ-020 DONE: Out_Valid=1; Sum/Co held stable until Out_Valid && Out_Ready, then go IDLE with Out_Valid=0 next cycle.
REQ-021 Latency: Out_Valid rises exactly 2 cycles after the edge accepting the final operand.
REQ-022 In_Valid low in ACCUM SHALL stall without changing S, C, count.
REQ-023 Out_Ready held low in DONE SHALL hold the result indefinitely; no operand lost (In_Ready=0).
REQ-024 Sum SHALL equal the arithmetic sum modulo 2^W_OUT; Co=1 only if the true sum of S and C reaches 2^W_OUT (0 for default parameters, maximum 2550).
REQ-025 Sum and Co SHALL change only in RESOLVE, reset, or clear.

Reset
REQ-026 Rst=1 at an edge SHALL force IDLE, S=0, C=0, count=0, Sum=0, Co=0, Out_Valid=0, regardless of state, including mid-ACCUM and DONE.
REQ-027 In_Ready SHALL be 1 in the first cycle after Rst deasserts.
REQ-028 Operands presented while Rst=1 SHALL be discarded.

Configuration
REQ-029 Macro CSA_ACC_CLEAR_EN: when defined, adds input Clear (1 bit); Clear=1 at an edge returns to IDLE, zeroes S, C, count, drops Out_Valid, leaves Sum/Co unchanged; In_Data presented with Clear is discarded; Rst has priority.
REQ-030 Without CSA_ACC_CLEAR_EN, no Clear port exists and only Rst aborts an accumulation.

Structure
REQ-031 Package csa_pkg SHALL hold the FSM state enum, default width constants, and the count width function (clog2(N_OPS+1)).
REQ-032 Sub-module csa_cell SHALL implement the W_OUT-bit 3:2 compressor (inputs x, y, z; outputs s, c) and be instantiated once.

Verification
REQ-033 Operands 1,2,...,10 back-to-back -> Sum=55, Co=0, Out_Valid 2 cycles after 10th accept.
REQ-034 Operands 0,0,3,4,...,10 with In_Valid gaps of 3 cycles after operands 2 and 7 -> Sum=52, Co=0, S/C unchanged during gaps.
REQ-035 Ten operands of 255 -> Sum=2550 (0x9F6), Co=0; then with N_OPS=16, sixteen operands of 255 -> Sum=4080, Co=0.
REQ-036 Out_Ready held low 20 cycles in DONE with In_Valid=1 -> Sum stable, In_Ready=0, no operand accepted; Out_Ready=1 -> IDLE next cycle, next set sums correctly.
REQ-037 Rst pulse after 5th operand, then operands 1..10 -> Sum=55, no residue from aborted set.
REQ-038 With CSA_ACC_CLEAR_EN, Clear after 4th operand, then 1..10 -> Sum=55; Clear in DONE drops Out_Valid, Sum keeps previous value.
